// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared pipeline definitions for the MEM stage:
//   - write-back select encodings (WB_MemtoReg)
//   - data-memory access FSM states
//   - default ack timeout
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  // Write-back select encodings. 2'b11 is reserved and behaves like ALU.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // Cycles to wait for dm_ack before an access is abandoned.
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// -----------------------------------------------------------------------------
// mem_access_stage_mem_wb
// MEM/WB pipeline register feeding the register file.
//   clk, rst      : clock, asynchronous active-low reset
//   bubble        : force the registered write enable to 0 this cycle
//   hold          : keep the registered destination and data unchanged
//   reg_write_in  : write enable from the MEM stage
//   addr_in       : destination register from the MEM stage
//   data_in       : selected write-back data from the MEM stage
//   reg_write     : registered write enable
//   addr          : registered destination register
//   data          : registered write-back data
// -----------------------------------------------------------------------------
module mem_access_stage_mem_wb
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        hold,
  input  logic        reg_write_in,
  input  logic [4:0]  addr_in,
  input  logic [31:0] data_in,
  output logic        reg_write,
  output logic [4:0]  addr,
  output logic [31:0] data
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write <= 1'b0;
      addr      <= '0;
      data      <= '0;
    end else begin
      reg_write <= bubble ? 1'b0 : reg_write_in;
      if (!hold) begin
        addr <= addr_in;
        data <= data_in;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the pipeline. Issues data-memory accesses over a req/ack bus,
// stalls the front of the pipe while an access is outstanding, selects the
// write-back data and registers the MEM/WB outputs.
//   clk, rst            : clock, asynchronous active-low reset
//   WB_MemtoReg_mem     : write-back select (ALU / load / PC+4)
//   WB_RegWrite_mem     : register-file write enable
//   MEM_MemWrite_mem    : store enable
//   RegWriteAddr_mem    : destination register
//   PC_mem              : PC of the instruction
//   ALUResult_mem       : effective address or ALU result
//   MemWriteData_mem    : store data
//   dm_req/we/addr/wdata: data-memory request (combinational)
//   dm_ack, dm_rdata    : data-memory completion and load data
//   mem_stall           : hold EX/MEM and earlier stages
//   *_wb                : registered MEM/WB outputs
//   bus_err             : one-cycle pulse, access timed out
//   align_err           : one-cycle pulse, misaligned access dropped
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WB_MemtoReg_mem,
  input  logic        WB_RegWrite_mem,
  input  logic        MEM_MemWrite_mem,
  input  logic [4:0]  RegWriteAddr_mem,
  input  logic [31:0] PC_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemWriteData_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        WB_RegWrite_wb,
  output logic [4:0]  RegWriteAddr_wb,
  output logic [31:0] RegWriteData_wb,
  output logic        bus_err,
  output logic        align_err
);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic        is_access;
  logic        misaligned;
  logic        need;
  logic        at_limit;
  logic        done;
  logic        timed_out;
  logic [31:0] load_data;
  logic [31:0] wb_data;

  // Access classification. Misaligned accesses are dropped before the bus.
  assign is_access  = MEM_MemWrite_mem | (WB_MemtoReg_mem == WB_SEL_MEM);
  assign misaligned = is_access & (ALUResult_mem[1:0] != 2'b00);
  assign need       = is_access & ~misaligned;

  assign dm_req   = need;
  assign dm_we    = MEM_MemWrite_mem;
  assign dm_addr  = ALUResult_mem;
  assign dm_wdata = MemWriteData_mem;

  // An ack on the last allowed cycle wins over the timeout.
  assign at_limit  = (state == ACCESS) && (cnt == CNT_W'(TIMEOUT - 1));
  assign done      = dm_ack | at_limit;
  assign timed_out = need & at_limit & ~dm_ack;

  // Combinational so a zero-wait memory costs no stall cycle.
  assign mem_stall = need & ~done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (need && !dm_ack) state_next = ACCESS;
      end
      ACCESS: begin
        cnt_next = cnt + CNT_W'(1);
        // Leaving also covers the request vanishing, so the FSM never sticks.
        if (done || !need) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Write-back select; an abandoned load returns zero.
  always_comb begin
    load_data = timed_out ? 32'h0 : dm_rdata;
    wb_data   = ALUResult_mem;
    case (WB_MemtoReg_mem)
      WB_SEL_MEM: wb_data = load_data;
      WB_SEL_PC4: wb_data = PC_mem + 32'd4;
      default:    wb_data = ALUResult_mem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      bus_err   <= timed_out;
      align_err <= misaligned;
    end
  end

  mem_access_stage_mem_wb u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (mem_stall),
    .hold         (mem_stall),
    .reg_write_in (WB_RegWrite_mem & ~misaligned),
    .addr_in      (RegWriteAddr_mem),
    .data_in      (wb_data),
    .reg_write    (WB_RegWrite_wb),
    .addr         (RegWriteAddr_wb),
    .data         (RegWriteData_wb)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Scoreboard bench: the driver computes each instruction's write-back result
// from the stage's rules and queues it; a monitor pops and compares whenever
// the stage retires an instruction into MEM/WB.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB_MemtoReg_mem;
  logic        WB_RegWrite_mem;
  logic        MEM_MemWrite_mem;
  logic [4:0]  RegWriteAddr_mem;
  logic [31:0] PC_mem;
  logic [31:0] ALUResult_mem;
  logic [31:0] MemWriteData_mem;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic        WB_RegWrite_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] RegWriteData_wb;
  logic        bus_err;
  logic        align_err;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .WB_MemtoReg_mem  (WB_MemtoReg_mem),
    .WB_RegWrite_mem  (WB_RegWrite_mem),
    .MEM_MemWrite_mem (MEM_MemWrite_mem),
    .RegWriteAddr_mem (RegWriteAddr_mem),
    .PC_mem           (PC_mem),
    .ALUResult_mem    (ALUResult_mem),
    .MemWriteData_mem (MemWriteData_mem),
    .dm_req           (dm_req),
    .dm_we            (dm_we),
    .dm_addr          (dm_addr),
    .dm_wdata         (dm_wdata),
    .dm_ack           (dm_ack),
    .dm_rdata         (dm_rdata),
    .mem_stall        (mem_stall),
    .WB_RegWrite_wb   (WB_RegWrite_wb),
    .RegWriteAddr_wb  (RegWriteAddr_wb),
    .RegWriteData_wb  (RegWriteData_wb),
    .bus_err          (bus_err),
    .align_err        (align_err)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_data;
    logic        bus_err;
    logic        align_err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs(input logic [1:0] sel, input logic we, input logic rw,
                              input logic [4:0] rd, input logic [31:0] pc,
                              input logic [31:0] alu, input logic [31:0] wdata);
    WB_MemtoReg_mem  = sel;
    MEM_MemWrite_mem = we;
    WB_RegWrite_mem  = rw;
    RegWriteAddr_mem = rd;
    PC_mem           = pc;
    ALUResult_mem    = alu;
    MemWriteData_mem = wdata;
  endtask

  // Present one instruction to the stage, starting just after a rising edge.
  // The access completes on the cycle the memory acks, or is abandoned on
  // cycle TIMEOUT counted from the cycle it was first presented (cycle 0).
  task automatic issue(input logic [1:0] sel, input logic we, input logic rw,
                       input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] wdata,
                       input int ack_delay, input logic [31:0] load_data);
    bit   is_access;
    bit   mis;
    bit   need;
    bit   to;
    int   last;
    exp_t e;
    is_access = we || (sel == 2'b01);
    mis       = is_access && (alu[1:0] != 2'b00);
    need      = is_access && !mis;
    to        = need && (ack_delay > TIMEOUT);
    last      = !need ? 0 : (to ? TIMEOUT : ack_delay);

    case (sel)
      2'b01:   e.data = to ? 32'h0 : load_data;
      2'b10:   e.data = pc + 32'd4;
      default: e.data = alu;
    endcase
    e.rw        = rw && !mis;
    e.addr      = rd;
    e.chk_data  = !mis;
    e.bus_err   = to;
    e.align_err = mis;
    sb.push_back(e);

    drive_inputs(sel, we, rw, rd, pc, alu, wdata);
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      // Acks on a cycle without a request must be ignored, so toggle them freely.
      dm_ack   = need ? (k == ack_delay) : 1'($urandom);
      dm_rdata = (need && k == ack_delay) ? load_data : $urandom;
      @(negedge clk);
      check("mem_stall", 32'(mem_stall), 32'(k < last));
      if (k == 0) begin
        check("dm_req", 32'(dm_req), 32'(need));
        if (need) begin
          check("dm_we", 32'(dm_we), 32'(we));
          check("dm_addr", dm_addr, alu);
          check("dm_wdata", dm_wdata, wdata);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: an instruction retires on every edge where the stage is not stalling.
  initial begin
    forever begin
      bit   active;
      bit   retire;
      exp_t e;
      @(negedge clk);
      active = mon_en;
      retire = !mem_stall;
      @(posedge clk);
      #1;
      if (active) begin
        if (retire) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_pop: stage retired an instruction, 0 pending, expected at least 1");
          end else begin
            e = sb.pop_front();
            check("wb_regwrite", 32'(WB_RegWrite_wb), 32'(e.rw));
            check("wb_addr", 32'(RegWriteAddr_wb), 32'(e.addr));
            if (e.chk_data) check("wb_data", RegWriteData_wb, e.data);
            check("bus_err", 32'(bus_err), 32'(e.bus_err));
            check("align_err", 32'(align_err), 32'(e.align_err));
          end
        end else begin
          check("bubble_regwrite", 32'(WB_RegWrite_wb), 32'd0);
          check("bubble_bus_err", 32'(bus_err), 32'd0);
          check("bubble_align_err", 32'(align_err), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  sel;
    logic        we;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] pc;
    int          r;
    int          ad;

    rst = 1'b0;
    drive_inputs(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    #1;
    check("rst_regwrite", 32'(WB_RegWrite_wb), 32'd0);
    check("rst_addr", 32'(RegWriteAddr_wb), 32'd0);
    check("rst_data", RegWriteData_wb, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_align_err", 32'(align_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Directed cases.
    issue(2'b00, 1'b0, 1'b1, 5'd5,  32'h0000_1000, 32'h0000_1234, 32'h0, 0, 32'h0);
    issue(2'b01, 1'b0, 1'b1, 5'd7,  32'h0000_1004, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    issue(2'b00, 1'b1, 1'b0, 5'd0,  32'h0000_1008, 32'h0000_0040, 32'hA5A5_A5A5, 0, 32'h0);
    issue(2'b10, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0000_0777, 32'h0, 0, 32'h0);
    issue(2'b01, 1'b0, 1'b1, 5'd8,  32'h0000_1010, 32'h0000_0102, 32'h0, 0, 32'h0);
    issue(2'b01, 1'b0, 1'b1, 5'd9,  32'h0000_1014, 32'h0000_0200, 32'h0, NEVER, 32'h1234_5678);
    issue(2'b01, 1'b0, 1'b1, 5'd10, 32'h0000_1018, 32'h0000_0204, 32'h0, TIMEOUT, 32'hCAFE_F00D);
    issue(2'b11, 1'b0, 1'b1, 5'd11, 32'h0000_101C, 32'h0BAD_0001, 32'h0, 0, 32'h0);
    issue(2'b00, 1'b1, 1'b1, 5'd12, 32'h0000_1020, 32'h0000_0041, 32'h5555_5555, 0, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      sel = 2'($urandom_range(0, 3));
      we  = ($urandom_range(0, 3) == 0);
      rw  = 1'($urandom);
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      pc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      r   = $urandom_range(0, 9);
      ad  = (r < 7) ? $urandom_range(0, 4) : ((r < 9) ? $urandom_range(5, TIMEOUT) : NEVER);
      issue(sel, we, rw, 5'($urandom), pc, alu, $urandom, ad, $urandom);
    end

    // Reset in the middle of an outstanding access.
    mon_en = 1'b0;
    drive_inputs(2'b00, 1'b0, 1'b1, 5'd5, 32'h0, 32'h0000_1234, 32'h0);
    dm_ack = 1'b0;
    @(posedge clk);
    #1;
    drive_inputs(2'b01, 1'b0, 1'b1, 5'd6, 32'h0, 32'h0000_0300, 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midacc_stall", 32'(mem_stall), 32'd1);
    check("midacc_hold_addr", 32'(RegWriteAddr_wb), 32'd5);
    check("midacc_hold_data", RegWriteData_wb, 32'h0000_1234);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_regwrite", 32'(WB_RegWrite_wb), 32'd0);
    check("midrst_addr", 32'(RegWriteAddr_wb), 32'd0);
    check("midrst_data", RegWriteData_wb, 32'd0);
    check("midrst_bus_err", 32'(bus_err), 32'd0);
    check("midrst_align_err", 32'(align_err), 32'd0);
    drive_inputs(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    dm_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("late_ack_stall", 32'(mem_stall), 32'd0);
      check("late_ack_req", 32'(dm_req), 32'd0);
      check("late_ack_bus_err", 32'(bus_err), 32'd0);
      check("late_ack_regwrite", 32'(WB_RegWrite_wb), 32'd0);
    end
    dm_ack = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(2'b01, 1'b0, 1'b1, 5'd13, 32'h0000_2000, 32'h0000_0400, 32'h0, 2, 32'h0F0F_1234);
    mon_en = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
